// File: rtl/wb_burst_responder.sv
// wb_burst_responder: Wishbone slave that turns single and wrapping 4/8-beat read bursts (and
// single writes) into a request/acknowledge handshake on a simple memory port.
//
// Ports
//   i_clk, i_rst            : clock, synchronous active-high reset
//   wb_cyc/wb_stb/wb_we     : Wishbone cycle, strobe, write enable
//   wb_adr/wb_i_dat/wb_sel  : word address, write data, byte lanes
//   wb_4_burst/wb_8_burst   : burst length request, sampled with the first strobe only
//   wb_ack/wb_err/wb_rty    : one-cycle termination strobes (gated by wb_cyc)
//   wb_o_dat                : read data, held until the next read acknowledge
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : memory request, stable until mem_ack
//   mem_rdata/mem_ack/mem_busy               : memory response and busy indication

`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif

module wb_burst_responder #(
  parameter logic [`WB_ADDR_W-1:0] ADDR_LIMIT = 24'h100000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [`WB_ADDR_W-1:0] wb_adr,
  input  logic [15:0]           wb_i_dat,
  input  logic [1:0]            wb_sel,
  input  logic                  wb_4_burst,
  input  logic                  wb_8_burst,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic                  wb_rty,
  output logic [15:0]           wb_o_dat,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [`WB_ADDR_W-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic [1:0]            mem_be,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_ack,
  input  logic                  mem_busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StAck, StAbort} state_e;

  state_e                  r_state;
  logic                    r_ack;
  logic                    r_err;
  logic                    r_rty;
  logic [15:0]             r_o_dat;
  logic                    r_mem_req;
  logic                    r_mem_we;
  logic [`WB_ADDR_W-1:0]   r_mem_addr;
  logic [15:0]             r_mem_wdata;
  logic [1:0]              r_mem_be;
  logic                    r_wrap8;
  logic [2:0]              r_beats;      // beats still to run after the current one

  logic                    w_req;
  logic                    w_bad;
  logic [`WB_ADDR_W-1:0]   w_next_adr;

  // A termination strobe in flight means the initiator has not yet seen it, so its still-high
  // strobe must not be taken as a fresh request.
  assign w_req = wb_cyc & wb_stb & ~(r_ack | r_err | r_rty);

  assign w_bad = (wb_4_burst & wb_8_burst) |
                 ((wb_4_burst | wb_8_burst) & wb_we) |
                 (wb_adr >= ADDR_LIMIT);

  // Wrapping increment inside the aligned 4- or 8-word block; upper bits never change.
  always_comb begin
    w_next_adr = r_mem_addr;
    if (r_wrap8) begin
      w_next_adr[2:0] = r_mem_addr[2:0] + 3'd1;
    end else begin
      w_next_adr[1:0] = r_mem_addr[1:0] + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_rty       <= 1'b0;
      r_o_dat     <= 16'h0000;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 16'h0000;
      r_mem_be    <= 2'b00;
      r_wrap8     <= 1'b0;
      r_beats     <= 3'd0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_rty <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
            if (w_bad) begin
              r_err <= 1'b1;
            end else if (wb_we && (wb_sel == 2'b00)) begin
              // Nothing to write: acknowledge without touching memory.
              r_ack   <= 1'b1;
              r_beats <= 3'd0;
              r_state <= StAck;
            end else if (mem_busy) begin
              r_rty <= 1'b1;
            end else begin
              r_state     <= StAccess;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= wb_adr;
              r_mem_we    <= wb_we;
              r_mem_wdata <= wb_i_dat;
              r_mem_be    <= wb_we ? wb_sel : 2'b11;
              r_wrap8     <= wb_8_burst;
              r_beats     <= wb_8_burst ? 3'd7 : (wb_4_burst ? 3'd3 : 3'd0);
            end
          end
        end
        StAccess: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (wb_cyc) begin
              r_ack   <= 1'b1;
              r_state <= StAck;
              if (!r_mem_we) begin
                r_o_dat <= mem_rdata;
              end
            end else begin
              r_state <= StIdle;
            end
          end else if (!wb_cyc) begin
            // Memory already saw the request; keep it up until it completes.
            r_state <= StAbort;
          end
        end
        StAbort: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= StIdle;
          end
        end
        StAck: begin
          if (wb_cyc && (r_beats != 3'd0)) begin
            r_state    <= StAccess;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_next_adr;
            r_beats    <= r_beats - 3'd1;
          end else begin
            r_state <= StIdle;
            r_beats <= 3'd0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Terminations vanish as soon as the initiator drops the cycle.
  assign wb_ack    = r_ack & wb_cyc;
  assign wb_err    = r_err & wb_cyc;
  assign wb_rty    = r_rty & wb_cyc;
  assign wb_o_dat  = r_o_dat;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_wb_burst_responder.sv
`timescale 1ns/1ps
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif

module tb_wb_burst_responder;
  localparam int AW = `WB_ADDR_W;
  localparam logic [AW-1:0] LIMIT = 24'h100000;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [15:0]   wb_i_dat;
  logic [1:0]    wb_sel;
  logic          wb_4_burst, wb_8_burst;
  logic          wb_ack, wb_err, wb_rty;
  logic [15:0]   wb_o_dat;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [1:0]    mem_be;
  logic [15:0]   mem_rdata;
  logic          mem_ack, mem_busy;

  always #5 i_clk = ~i_clk;

  wb_burst_responder #(.ADDR_LIMIT(LIMIT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_i_dat(wb_i_dat), .wb_sel(wb_sel),
    .wb_4_burst(wb_4_burst), .wb_8_burst(wb_8_burst),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty), .wb_o_dat(wb_o_dat),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_busy(mem_busy)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  always @(posedge i_clk) cycle <= cycle + 1;

  // Expected outputs for the current cycle, set by the stimulus/model process.
  logic          e_ack, e_err, e_rty, e_req, e_we, e_full;
  logic [15:0]   e_dat, e_wdata;
  logic [AW-1:0] e_addr;
  logic [1:0]    e_be;
  bit            cmp_en = 0;
  bit            use_fix = 0;
  logic [15:0]   rd_fix;

  logic [AW-1:0] acc_log[$];
  int            ack_cycles[$];

  logic [AW-1:0] exp30 [4] = '{24'h6, 24'h7, 24'h4, 24'h5};
  logic [AW-1:0] exp31 [8] = '{24'h1d, 24'h1e, 24'h1f, 24'h18, 24'h19, 24'h1a, 24'h1b, 24'h1c};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("wb_ack", wb_ack, e_ack);
      chk("wb_err", wb_err, e_err);
      chk("wb_rty", wb_rty, e_rty);
      chk("wb_o_dat", wb_o_dat, e_dat);
      chk("mem_req", mem_req, e_req);
      if (e_req || e_full) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", mem_we, e_we);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_be", mem_be, e_be);
      end
      if (wb_ack) ack_cycles.push_back(cycle);
      if (mem_req && mem_ack) acc_log.push_back(mem_addr);
    end
  end

  task automatic idle_exp();
    e_ack = 0; e_err = 0; e_rty = 0; e_req = 0; e_full = 0;
  endtask

  task automatic zero_exp();
    idle_exp();
    e_full = 1; e_addr = '0; e_we = 0; e_wdata = '0; e_be = '0; e_dat = '0;
  endtask

  // Advance one cycle; inputs the responder must ignore get fresh random values.
  task automatic tick();
    @(posedge i_clk);
    #1;
    wb_adr = AW'($urandom); wb_i_dat = 16'($urandom);
    wb_4_burst = 1'($urandom); wb_8_burst = 1'($urandom);
    mem_busy = 1'($urandom); mem_rdata = 16'($urandom);
  endtask

  // One complete Wishbone transaction with the expected response computed from the rules.
  task automatic do_txn(input bit we, input logic [AW-1:0] adr, input logic [15:0] dat,
                        input logic [1:0] sel, input bit b4, input bit b8, input bit busy,
                        input int wait_fix, input int drop_beat, input bit drop_ack,
                        input int rst_beat);
    int n, w;
    bit bad, nowr;
    int unsigned base, blk;
    logic [AW-1:0] a;
    logic [15:0] rd;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_i_dat = dat; wb_sel = sel;
    wb_4_burst = b4; wb_8_burst = b8; mem_busy = busy; mem_ack = 0;
    idle_exp();
    tick();
    bad  = (b4 && b8) || ((b4 || b8) && we) || (adr >= LIMIT);
    nowr = we && (sel == 2'b00);
    n = b8 ? 8 : (b4 ? 4 : 1);
    if (bad || nowr || busy) begin
      e_err = bad;
      e_ack = !bad && nowr;
      e_rty = !bad && !nowr && busy;
      tick();
      wb_cyc = 0; wb_stb = 0; idle_exp();
      tick();
      return;
    end
    base = adr;
    blk  = base - (base % n);
    for (int k = 0; k < n; k++) begin
      a = AW'(blk + ((base - blk + k) % n));
      w = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 2));
      e_req = 1; e_addr = a; e_we = we; e_wdata = dat; e_be = we ? sel : 2'b11;
      mem_ack = 0;
      if (rst_beat == k) begin
        i_rst = 1; mem_ack = 1;
        tick();
        i_rst = 0; wb_cyc = 0; wb_stb = 0; mem_ack = 1;   // late ack must be ignored
        zero_exp();
        tick();
        mem_ack = 0;
        tick();
        idle_exp();
        return;
      end
      if (drop_beat == k && !drop_ack) begin
        wb_cyc = 0; wb_stb = 0;
        tick();
        repeat (w) begin mem_ack = 0; tick(); end
        mem_ack = 1;
        tick();
        mem_ack = 0; idle_exp();
        tick();
        return;
      end
      repeat (w) begin mem_ack = 0; tick(); end
      rd = use_fix ? rd_fix : 16'($urandom);
      mem_ack = 1; mem_rdata = rd;
      tick();
      mem_ack = 0; e_req = 0;
      if (!we) e_dat = rd;
      if (drop_ack && drop_beat == k) begin
        wb_cyc = 0; wb_stb = 0; e_ack = 0;
        tick();
        idle_exp();
        tick();
        return;
      end
      e_ack = 1;
      tick();
      e_ack = 0;
    end
    wb_cyc = 0; wb_stb = 0; idle_exp();
    tick();
  endtask

  initial begin
    int c0, n, dropb, rstb, bl;
    bit we, b4, b8, busy, dack;
    logic [1:0] sel;
    logic [AW-1:0] adr;

    i_rst = 1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_i_dat = '0; wb_sel = '0;
    wb_4_burst = 0; wb_8_burst = 0; mem_rdata = '0; mem_ack = 0; mem_busy = 0;
    zero_exp();
    @(posedge i_clk); #1;
    cmp_en = 1;
    @(posedge i_clk); #1;
    i_rst = 0;
    tick();
    idle_exp();

    // Single zero-wait read.
    acc_log.delete(); ack_cycles.delete();
    use_fix = 1; rd_fix = 16'hBEEF; c0 = cycle;
    do_txn(0, 24'h10, 16'h0, 2'b11, 0, 0, 0, 0, -1, 0, -1);
    use_fix = 0;
    chk("r29_dat", wb_o_dat, 16'hBEEF);
    chk("r29_nack", ack_cycles.size(), 1);
    chk("r29_ackcyc", ack_cycles[0] - c0, 2);
    chk("r29_addr", acc_log[0], 24'h10);

    // 4-beat wrapping read.
    acc_log.delete(); ack_cycles.delete(); c0 = cycle;
    do_txn(0, 24'h6, 16'h0, 2'b10, 1, 0, 0, 0, -1, 0, -1);
    chk("r30_nacc", acc_log.size(), 4);
    chk("r30_nack", ack_cycles.size(), 4);
    for (int i = 0; i < 4; i++) chk("r30_addr", acc_log[i], exp30[i]);
    chk("r30_last", ack_cycles[3] - c0, 8);

    // 8-beat read, two wait cycles per beat.
    acc_log.delete(); ack_cycles.delete(); c0 = cycle;
    do_txn(0, 24'h1d, 16'h0, 2'b11, 0, 1, 0, 2, -1, 0, -1);
    chk("r31_nack", ack_cycles.size(), 8);
    chk("r31_first", ack_cycles[0] - c0, 4);
    for (int i = 1; i < 8; i++) chk("r31_space", ack_cycles[i] - ack_cycles[i-1], 4);
    for (int i = 0; i < 8; i++) chk("r31_addr", acc_log[i], exp31[i]);

    // Single write.
    acc_log.delete(); ack_cycles.delete();
    do_txn(1, 24'h20, 16'h1234, 2'b01, 0, 0, 0, 1, -1, 0, -1);
    chk("r32_nack", ack_cycles.size(), 1);
    chk("r32_nacc", acc_log.size(), 1);

    // Error / retry / empty-write paths: none may reach memory.
    acc_log.delete(); ack_cycles.delete();
    do_txn(0, LIMIT, 16'h0, 2'b11, 0, 0, 0, 0, -1, 0, -1);
    do_txn(0, 24'h40, 16'h0, 2'b11, 1, 1, 0, 0, -1, 0, -1);
    do_txn(1, 24'h40, 16'h5555, 2'b11, 1, 0, 0, 0, -1, 0, -1);
    do_txn(0, 24'h44, 16'h0, 2'b11, 0, 0, 1, 0, -1, 0, -1);
    do_txn(1, 24'h48, 16'haaaa, 2'b00, 0, 0, 0, 0, -1, 0, -1);
    chk("r33_nacc", acc_log.size(), 0);
    chk("r33_nack", ack_cycles.size(), 1);

    // Cycle dropped during beat 2 access, during an ack, and a reset mid-burst.
    ack_cycles.delete();
    do_txn(0, 24'h30, 16'h0, 2'b11, 1, 0, 0, 2, 1, 0, -1);
    chk("r34_nack", ack_cycles.size(), 1);
    do_txn(0, 24'h34, 16'h0, 2'b11, 1, 0, 0, 1, 2, 1, -1);
    do_txn(0, 24'h38, 16'h0, 2'b11, 0, 1, 0, 1, -1, 0, 2);
    do_txn(0, 24'h3c, 16'h0, 2'b11, 0, 0, 0, 0, -1, 0, -1);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      we  = 1'($urandom);
      sel = 2'($urandom);
      bl  = int'($urandom % 4);
      b4  = (bl == 1); b8 = (bl == 2);
      if ($urandom % 10 == 0) begin b4 = 1; b8 = 1; end
      if (we && ($urandom % 4 != 0)) begin b4 = 0; b8 = 0; end
      adr = ($urandom % 12 == 0) ? LIMIT + AW'($urandom % 16) : AW'($urandom % 32'h100000);
      busy = ($urandom % 8 == 0);
      if (we && sel == 2'b00) busy = 0;
      n = b8 ? 8 : (b4 ? 4 : 1);
      dropb = -1; rstb = -1; dack = 0;
      if ($urandom % 8 == 0) begin
        dropb = int'($urandom % n); dack = 1'($urandom);
      end else if ($urandom % 15 == 0) begin
        rstb = int'($urandom % n);
      end
      do_txn(we, adr, 16'($urandom), sel, b4, b8, busy, -1, dropb, dack, rstb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_burst_responder.md
WB_BURST_RESPONDER -- requirements
Module: wb_burst_responder

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 24'h100000; word addresses >= ADDR_LIMIT are out of range.
REQ-002 SHALL have port i_clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports wb_cyc, wb_stb, wb_we  input  1 each  Wishbone cycle, strobe, write-enable from initiator.
REQ-005 SHALL have port wb_adr  input  `WB_ADDR_W  word address; wb_i_dat input 16; wb_sel input 2 byte lanes.
REQ-006 SHALL have ports wb_4_burst, wb_8_burst  input  1 each  burst-length request, sampled with first strobe only.
REQ-007 SHALL have ports wb_ack, wb_err, wb_rty  output  1 each, and wb_o_dat  output  16  read data.
REQ-008 SHALL have memory-side ports mem_req, mem_we output 1; mem_addr output `WB_ADDR_W; mem_wdata output 16; mem_be output 2; mem_rdata input 16; mem_ack input 1; mem_busy input 1.

Function
REQ-009 SHALL implement states IDLE, ACCESS, ACK, ABORT.
REQ-010 IDLE with wb_cyc&wb_stb SHALL latch adr, dat, sel, we and beat count (1, 4 if wb_4_burst, 8 if wb_8_burst).
REQ-011 Request with both burst flags, burst with wb_we=1, or wb_adr >= ADDR_LIMIT SHALL produce one-cycle wb_err next cycle, no memory access, stay IDLE.
REQ-012 Valid request while mem_busy=1 SHALL produce one-cycle wb_rty next cycle, no memory access; err conditions take priority over rty.
REQ-013 Otherwise SHALL enter ACCESS next cycle with mem_req=1, mem_addr, mem_we, mem_wdata, mem_be driven from latched values.
REQ-014 In ACCESS mem_req and all mem_* outputs SHALL stay stable until the cycle mem_ack=1 is sampled.
REQ-015 On mem_ack SHALL register mem_rdata into wb_o_dat (reads only) and enter ACK; mem_req low in ACK.
REQ-016 ACK SHALL assert wb_ack for exactly one cycle; wb_o_dat valid in that cycle and held until next ack.
REQ-017 After ACK: remaining beats > 0 -> ACCESS next cycle with next address; else IDLE.
REQ-018 Burst address SHALL wrap within the aligned block: low 2 bits (4-burst) or low 3 bits (8-burst) increment mod 4/8, upper bits fixed; first beat uses wb_adr unmodified.
REQ-019 Minimum latency: strobe sampled cycle 0, mem_req cycle 1, mem_ack in cycle 1 -> wb_ack cycle 2; 4-burst with zero-wait memory completes in 8 cycles.
REQ-020 wb_adr, wb_i_dat and burst flags SHALL be ignored after first beat; wb_stb held high across burst is not a new request.
REQ-021 Write with wb_sel=2'b00 SHALL be acked in cycle 1 with no memory access.
REQ-022 Reads SHALL drive mem_be=2'b11 regardless of wb_sel.
REQ-023 wb_cyc low in ACCESS SHALL go to ABORT: mem_req held until mem_ack, then IDLE, no wb_ack.
REQ-024 wb_cyc low in ACK SHALL suppress that wb_ack and remaining beats; go IDLE.
REQ-025 wb_ack, wb_err, wb_rty SHALL be mutually exclusive and never asserted while wb_cyc=0.
REQ-026 New request SHALL be accepted only in IDLE; earliest acceptance is the cycle after the final ack/err/rty.

Reset
REQ-027 i_rst=1 SHALL force IDLE and zero wb_ack, wb_err, wb_rty, wb_o_dat, mem_req, mem_we, mem_addr, mem_wdata, mem_be, beat counter next edge.
REQ-028 Reset mid-burst SHALL drop mem_req immediately regardless of pending mem_ack; late mem_ack after reset SHALL be ignored.

Verification
REQ-029 Single read adr=0x000010, mem_rdata=0xBEEF, zero-wait -> mem_req cycle 1, wb_ack cycle 2 with wb_o_dat=0xBEEF.
REQ-030 4-burst read adr=0x000006 -> mem_addr sequence 6,7,4,5; four single-cycle acks; IDLE after 4th.
REQ-031 8-burst read with 2-cycle memory wait -> eight acks spaced 4 cycles apart, addresses wrap within aligned 8 block.
REQ-032 Write adr=0x000020, dat=0x1234, sel=2'b01 -> mem_we=1, mem_be=2'b01, mem_wdata=0x1234, one wb_ack.
REQ-033 adr=ADDR_LIMIT -> wb_err cycle 1, no mem_req; both burst flags -> wb_err; valid read with mem_busy=1 -> wb_rty cycle 1.
REQ-034 Drop wb_cyc during beat 2 of 4-burst -> mem_req held until mem_ack, no further acks, IDLE; repeat with i_rst mid-burst -> all outputs 0 next cycle.
